// File: rtl/test_completion_monitor_if.sv
// Probe taps into the monitor and the end-of-test status it reports.
// The system side is the master; the monitor is the slave.
interface test_completion_monitor_if #(
  parameter int NCH   = 1,
  parameter int CNT_W = 32
);
  logic              start;
  logic [NCH-1:0]    ev_hit;
  logic [NCH*32-1:0] ev_pc;
  logic [NCH*32-1:0] result;
  logic              tohost_wen;
  logic [31:0]       tohost_addr;
  logic [31:0]       tohost_wdata;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [3:0]        fail_ch;
  logic [31:0]       fail_code;
  logic [31:0]       ecall_pc;
  logic [CNT_W-1:0]  cycles;

  modport master (
    output start, ev_hit, ev_pc, result, tohost_wen, tohost_addr, tohost_wdata,
    input  done, pass, timeout, fail_ch, fail_code, ecall_pc, cycles
  );
  modport slave (
    input  start, ev_hit, ev_pc, result, tohost_wen, tohost_addr, tohost_wdata,
    output done, pass, timeout, fail_ch, fail_code, ecall_pc, cycles
  );
endinterface

// File: rtl/test_completion_monitor.sv
// End-of-test monitor: per-hart drain after an ECALL/exception or tohost write,
// then reports pass/fail, failing hart, its result and PC, cycle count, timeout.
module test_completion_monitor #(
  parameter int          NCH            = 1,
  parameter int          DRAIN_CYCLES   = 50,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter logic [31:0] PASS_VALUE     = 32'd1
) (
  input logic                      clk,
  input logic                      rst,
  test_completion_monitor_if.slave mon
);
  localparam int               DCW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0]   DRAIN_LOAD  = DCW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_REPORT} top_state_e;
  typedef enum logic [1:0] {CH_WAIT, CH_DRAIN, CH_DONE}    ch_state_e;

  top_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d, cycles_inc;
  logic              done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [3:0]        fail_ch_q, fail_ch_d;
  logic [31:0]       fail_code_q, fail_code_d, ecall_pc_q, ecall_pc_d;

  logic              running, tohost_hit, timeout_hit;
  logic [NCH-1:0]    ch_done_now, ch_done_next;
  logic [NCH*32-1:0] smp_flat, pc_flat;
  logic              all_pass;
  logic [3:0]        fail_idx, wait_idx;
  logic [31:0]       fail_val, fail_pc, wait_pc;

  assign running    = (state_q == TOP_RUN);
  assign tohost_hit = running && mon.tohost_wen && (mon.tohost_addr == TOHOST_ADDR)
                      && mon.tohost_wdata[0];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ch_state_e      st_q, st_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic [31:0]    pc_q, pc_d, smp_q, smp_d;
    logic           th_hit;

    // Only hart 0 owns the tohost mailbox.
    if (gi == 0) begin : g_th
      assign th_hit = tohost_hit;
    end else begin : g_no_th
      assign th_hit = 1'b0;
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      pc_d  = pc_q;
      smp_d = smp_q;
      if (mon.start) begin
        st_d  = CH_WAIT;
        cnt_d = '0;
        pc_d  = '0;
        smp_d = '0;
      end else if (running) begin
        case (st_q)
          CH_WAIT: begin
            if (mon.ev_hit[gi]) begin
              st_d  = CH_DRAIN;
              cnt_d = DRAIN_LOAD;
              pc_d  = mon.ev_pc[gi*32 +: 32];
            end
          end
          CH_DRAIN: begin
            if (cnt_q == '0) begin
              st_d  = CH_DONE;
              smp_d = mon.result[gi*32 +: 32];
            end else begin
              cnt_d = cnt_q - DCW'(1);
            end
          end
          default: ;
        endcase
        // A tohost write finishes the channel at once, even mid-drain; the PC latch above still applies.
        if (th_hit && (st_q != CH_DONE)) begin
          st_d  = CH_DONE;
          smp_d = mon.tohost_wdata;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= CH_WAIT;
        cnt_q <= '0;
        pc_q  <= '0;
        smp_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        pc_q  <= pc_d;
        smp_q <= smp_d;
      end
    end

    assign ch_done_now[gi]        = (st_q == CH_DONE);
    assign ch_done_next[gi]       = (st_d == CH_DONE);
    assign smp_flat[gi*32 +: 32]  = smp_q;
    assign pc_flat[gi*32 +: 32]   = pc_q;
  end

  // Lowest failing hart and lowest unfinished hart, scanned high-to-low so the lowest wins.
  always_comb begin
    all_pass = 1'b1;
    fail_idx = '0;
    fail_val = '0;
    fail_pc  = pc_flat[31:0];
    wait_idx = '0;
    wait_pc  = pc_flat[31:0];
    for (int i = NCH - 1; i >= 0; i--) begin
      if (smp_flat[i*32 +: 32] != PASS_VALUE) begin
        all_pass = 1'b0;
        fail_idx = 4'(i);
        fail_val = smp_flat[i*32 +: 32];
        fail_pc  = pc_flat[i*32 +: 32];
      end
      if (!ch_done_now[i]) begin
        wait_idx = 4'(i);
        wait_pc  = pc_flat[i*32 +: 32];
      end
    end
  end

  assign cycles_inc  = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycles_inc == TIMEOUT_VAL);

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_ch_d   = fail_ch_q;
    fail_code_d = fail_code_q;
    ecall_pc_d  = ecall_pc_q;
    if (mon.start) begin
      state_d     = TOP_RUN;
      cycles_d    = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_ch_d   = '0;
      fail_code_d = '0;
      ecall_pc_d  = '0;
    end else if (state_q == TOP_RUN) begin
      cycles_d = cycles_inc;
      if (&ch_done_now) begin
        state_d     = TOP_REPORT;
        done_d      = 1'b1;
        pass_d      = all_pass;
        fail_ch_d   = fail_idx;
        fail_code_d = fail_val;
        ecall_pc_d  = fail_pc;
      end else if (timeout_hit && !(&ch_done_next)) begin
        // A last channel finishing on the timeout cycle is reported as a completion instead.
        state_d     = TOP_REPORT;
        done_d      = 1'b1;
        timeout_d   = 1'b1;
        pass_d      = 1'b0;
        fail_ch_d   = wait_idx;
        fail_code_d = '0;
        ecall_pc_d  = wait_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TOP_IDLE;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_ch_q   <= '0;
      fail_code_q <= '0;
      ecall_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_ch_q   <= fail_ch_d;
      fail_code_q <= fail_code_d;
      ecall_pc_q  <= ecall_pc_d;
    end
  end

  assign mon.done      = done_q;
  assign mon.pass      = pass_q;
  assign mon.timeout   = timeout_q;
  assign mon.fail_ch   = fail_ch_q;
  assign mon.fail_code = fail_code_q;
  assign mon.ecall_pc  = ecall_pc_q;
  assign mon.cycles    = cycles_q;
endmodule

// File: tb/tb_test_completion_monitor.sv
// Bench for test_completion_monitor: a single-hart instance driven from a vector table,
// and a four-hart instance driven by directed and random runs against a completion-time model.
module tb_test_completion_monitor;
  localparam int          DRAIN_A = 50;
  localparam int          DRAIN_B = 6;
  localparam int          TO_B    = 200;
  localparam int          NB      = 4;
  localparam int          NEVER   = 1000000;
  localparam logic [31:0] TH_ADDR = 32'h8000_1000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  test_completion_monitor_if #(.NCH(1),  .CNT_W(32)) ifa ();
  test_completion_monitor_if #(.NCH(NB), .CNT_W(32)) ifb ();

  test_completion_monitor #(
    .NCH(1), .DRAIN_CYCLES(DRAIN_A), .TIMEOUT_CYCLES(100000), .CNT_W(32),
    .TOHOST_ADDR(TH_ADDR), .PASS_VALUE(32'd1)
  ) dut_a (.clk(clk), .rst(rst), .mon(ifa));

  test_completion_monitor #(
    .NCH(NB), .DRAIN_CYCLES(DRAIN_B), .TIMEOUT_CYCLES(TO_B), .CNT_W(32),
    .TOHOST_ADDR(TH_ADDR), .PASS_VALUE(32'd1)
  ) dut_b (.clk(clk), .rst(rst), .mon(ifb));

  typedef struct {
    int          hit_e;
    logic [31:0] res;
    logic [31:0] pc;
    int          th_e;
    logic [31:0] th_addr;
    logic [31:0] th_data;
    int          exp_e;
    logic        exp_pass;
    logic [31:0] exp_code;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vt [8];
  int          bt   [NB];
  logic [31:0] bres [NB];
  int          bth;
  logic [31:0] btha, bthd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifa.start = 1'b0; ifa.ev_hit = '0; ifa.ev_pc = '0; ifa.result = '0;
    ifa.tohost_wen = 1'b0; ifa.tohost_addr = '0; ifa.tohost_wdata = '0;
    ifb.start = 1'b0; ifb.ev_hit = '0; ifb.ev_pc = '0; ifb.result = '0;
    ifb.tohost_wen = 1'b0; ifb.tohost_addr = '0; ifb.tohost_wdata = '0;
  endtask

  // Edge e is the e-th rising edge after the one that sampled start.
  task automatic run_a(input vec_t v, input string tag);
    int done_e;
    done_e = -1;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    chk({tag, "_start_clear"}, {ifa.done, ifa.pass, ifa.timeout, ifa.cycles}, 64'd0);
    for (int e = 1; e <= 400 && done_e < 0; e++) begin
      ifa.ev_hit       = 1'(e == v.hit_e);
      ifa.ev_pc        = (e == v.hit_e) ? v.pc : $urandom;
      ifa.result       = v.res;
      ifa.tohost_wen   = 1'(e == v.th_e);
      ifa.tohost_addr  = (e == v.th_e) ? v.th_addr : $urandom;
      ifa.tohost_wdata = (e == v.th_e) ? v.th_data : $urandom;
      @(negedge clk);
      if (ifa.done) done_e = e;
    end
    idle_inputs();
    chk({tag, "_done_edge"}, done_e, v.exp_e);
    chk({tag, "_pass"}, ifa.pass, v.exp_pass);
    chk({tag, "_timeout"}, ifa.timeout, 1'b0);
    chk({tag, "_fail_ch"}, ifa.fail_ch, 4'd0);
    chk({tag, "_fail_code"}, ifa.fail_code, v.exp_code);
    chk({tag, "_ecall_pc"}, ifa.ecall_pc, v.exp_pc);
    chk({tag, "_cycles"}, ifa.cycles, v.exp_e);
    $display("A %s: done@%0d pass=%0d code=0x%0h pc=0x%0h cycles=%0d",
             tag, done_e, ifa.pass, ifa.fail_code, ifa.ecall_pc, ifa.cycles);
  endtask

  // Model: each hart completes DRAIN_B edges after its first hit (or at a valid tohost
  // write for hart 0); the report lands one edge after the last completion, or at TO_B.
  task automatic run_b(input string tag);
    int          d [NB];
    logic [31:0] smp [NB];
    logic [31:0] pcs [NB];
    logic [NB-1:0] hit;
    logic [31:0] pcv;
    int          dmax, done_e, e_r, fc;
    logic        e_to, e_pass;
    logic [31:0] e_code, e_pc;
    for (int i = 0; i < NB; i++) begin
      d[i]   = (bt[i] > 0) ? bt[i] + DRAIN_B : NEVER;
      smp[i] = bres[i];
      pcs[i] = '0;
    end
    if (bth > 0 && btha == TH_ADDR && bthd[0] && bth <= d[0]) begin
      d[0]   = bth;
      smp[0] = bthd;
    end
    dmax = 0;
    for (int i = 0; i < NB; i++) if (d[i] > dmax) dmax = d[i];

    done_e = -1;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    chk({tag, "_start_clear"}, {ifb.done, ifb.timeout, ifb.fail_code, ifb.cycles}, 64'd0);
    for (int e = 1; e <= TO_B + 20 && done_e < 0; e++) begin
      for (int i = 0; i < NB; i++) begin
        hit[i] = (e == bt[i]) || (bt[i] > 0 && e > bt[i] &&
                 (e == bt[i] + 2 || $urandom_range(0, 9) == 0));
        ifb.result[i*32 +: 32] = (e <= d[i]) ? bres[i] : $urandom;
        pcv = $urandom;
        ifb.ev_pc[i*32 +: 32] = pcv;
        if (e == bt[i]) pcs[i] = pcv;
      end
      ifb.ev_hit       = hit;
      ifb.tohost_wen   = 1'(e == bth);
      ifb.tohost_addr  = (e == bth) ? btha : $urandom;
      ifb.tohost_wdata = (e == bth) ? bthd : $urandom;
      @(negedge clk);
      if (ifb.done) done_e = e;
    end
    idle_inputs();

    if (dmax > TO_B) begin
      e_r = TO_B; e_to = 1'b1; e_pass = 1'b0; e_code = '0; fc = -1;
      for (int i = NB - 1; i >= 0; i--) if (d[i] >= TO_B) fc = i;
      e_pc = (bt[fc] > 0 && bt[fc] <= d[fc] && bt[fc] < TO_B) ? pcs[fc] : 32'd0;
    end else begin
      e_r = dmax + 1; e_to = 1'b0; fc = 0; e_pass = 1'b1; e_code = '0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (smp[i] != 32'd1) begin
          fc = i; e_pass = 1'b0; e_code = smp[i];
        end
      end
      e_pc = (bt[fc] > 0 && bt[fc] <= d[fc]) ? pcs[fc] : 32'd0;
    end

    chk({tag, "_done_edge"}, done_e, e_r);
    chk({tag, "_timeout"}, ifb.timeout, e_to);
    chk({tag, "_pass"}, ifb.pass, e_pass);
    chk({tag, "_fail_ch"}, ifb.fail_ch, 4'(fc));
    chk({tag, "_fail_code"}, ifb.fail_code, e_code);
    chk({tag, "_ecall_pc"}, ifb.ecall_pc, e_pc);
    chk({tag, "_cycles"}, ifb.cycles, e_r);

    // Events and valid tohost writes while reporting must leave the report untouched.
    for (int k = 0; k < 4; k++) begin
      ifb.ev_hit = NB'($urandom);
      ifb.tohost_wen = 1'b1; ifb.tohost_addr = TH_ADDR; ifb.tohost_wdata = 32'hB;
      @(negedge clk);
    end
    idle_inputs();
    chk({tag, "_hold"}, {ifb.done, ifb.fail_code, ifb.cycles}, {1'b1, e_code, 32'(e_r)});
    $display("B %s: done@%0d to=%0d pass=%0d ch=%0d code=0x%0h pc=0x%0h cycles=%0d",
             tag, done_e, ifb.timeout, ifb.pass, ifb.fail_ch, ifb.fail_code,
             ifb.ecall_pc, ifb.cycles);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    vt[0] = '{100, 32'd1, 32'h0000_0100, 0,  TH_ADDR,          32'd0,  151, 1'b1, 32'd0,  32'h0000_0100};
    vt[1] = '{10,  32'd7, 32'h0000_2000, 0,  TH_ADDR,          32'd0,  61,  1'b0, 32'd7,  32'h0000_2000};
    vt[2] = '{0,   32'd1, 32'h0,         20, TH_ADDR,          32'd1,  21,  1'b1, 32'd0,  32'h0};
    vt[3] = '{0,   32'd1, 32'h0,         20, TH_ADDR,          32'hB,  21,  1'b0, 32'hB,  32'h0};
    vt[4] = '{5,   32'd1, 32'h0000_3000, 30, TH_ADDR,          32'hB,  31,  1'b0, 32'hB,  32'h0000_3000};
    vt[5] = '{40,  32'd1, 32'h0000_4000, 20, TH_ADDR + 32'd4,  32'd1,  91,  1'b1, 32'd0,  32'h0000_4000};
    vt[6] = '{40,  32'd3, 32'h0000_5000, 20, TH_ADDR,          32'd2,  91,  1'b0, 32'd3,  32'h0000_5000};
    vt[7] = '{25,  32'd5, 32'h0000_6000, 25, TH_ADDR,          32'd1,  26,  1'b1, 32'd0,  32'h0000_6000};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_a", {ifa.done, ifa.pass, ifa.timeout, ifa.fail_ch, ifa.fail_code, ifa.cycles}, 64'd0);
    chk("reset_b", {ifb.done, ifb.pass, ifb.timeout, ifb.fail_ch, ifb.ecall_pc, ifb.cycles}, 64'd0);

    for (int r = 0; r < 8; r++) run_a(vt[r], $sformatf("vec%0d", r));

    // Reset in the middle of a drain returns to idle; a new start begins a fresh count.
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      ifa.ev_hit = 1'(e == 10); ifa.ev_pc = 32'h0000_7000; ifa.result = 32'd1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_drain", {ifa.done, ifa.pass, ifa.timeout, ifa.ecall_pc, ifa.cycles}, 64'd0);
    seen_done = 1'b0;
    for (int e = 0; e < 80; e++) begin
      ifa.ev_hit = 1'($urandom); ifa.tohost_wen = 1'b1; ifa.tohost_addr = TH_ADDR; ifa.tohost_wdata = 32'd1;
      @(negedge clk);
      if (ifa.done || ifa.cycles != 0) seen_done = 1'b1;
    end
    idle_inputs();
    chk("idle_ignores_events", seen_done, 1'b0);
    run_a(vt[1], "after_rst");

    bt = '{10, 20, 30, 40}; bres = '{32'd1, 32'd1, 32'd5, 32'd9}; bth = 0; btha = TH_ADDR; bthd = '0;
    run_b("stagger");
    chk("stagger_fail_ch", ifb.fail_ch, 4'd2);
    chk("stagger_fail_code", ifb.fail_code, 32'd5);
    chk("stagger_cycles", ifb.cycles, 32'd47);

    bt = '{10, 12, 14, 16}; bres = '{32'd1, 32'd3, 32'd1, 32'd1};
    run_b("rehit");
    chk("rehit_fail_ch", ifb.fail_ch, 4'd1);

    bt = '{0, 0, 0, 0};
    run_b("timeout");
    chk("timeout_flags", {ifb.done, ifb.timeout, ifb.pass, ifb.fail_ch}, {1'b1, 1'b1, 1'b0, 4'd0});
    chk("timeout_cycles", ifb.cycles, 32'd200);

    bt = '{194, 10, 10, 10}; bres = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_b("edge_complete");
    chk("edge_complete_to", {ifb.timeout, ifb.pass, ifb.cycles}, {1'b0, 1'b1, 32'd201});

    bt = '{195, 10, 10, 10};
    run_b("edge_timeout");
    chk("edge_timeout_to", {ifb.timeout, ifb.pass, ifb.cycles}, {1'b1, 1'b0, 32'd200});

    for (int r = 0; r < 36; r++) begin
      for (int i = 0; i < NB; i++) begin
        bt[i]   = ($urandom_range(0, 99) < 92) ? int'($urandom_range(1, 199)) : 0;
        bres[i] = ($urandom_range(0, 9) < 7) ? 32'd1 : $urandom;
      end
      bth  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 210)) : 0;
      btha = ($urandom_range(0, 4) == 0) ? TH_ADDR + 32'd4 : TH_ADDR;
      bthd = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
      run_b($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
